// File: rtl/common.sv
// Shared definitions for the memory-access stage: data-bus payloads, access
// sizes, control-bit positions, load funct3 codes and the stage FSM encoding.
package common;

  localparam int unsigned XLEN    = 64;
  localparam int unsigned STRB_W  = XLEN / 8;
  localparam int unsigned CTRL_W  = 24;
  localparam int unsigned INSTR_W = 32;

  // Control-word bit positions
  localparam logic [4:0] CTRL_MEMRD = 5'd4;
  localparam logic [4:0] CTRL_MEMWR = 5'd5;

  // Load funct3 codes (stores reuse bits [1:0] for the size)
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;

  typedef enum logic [1:0] {
    MSIZE1 = 2'b00,
    MSIZE2 = 2'b01,
    MSIZE4 = 2'b10,
    MSIZE8 = 2'b11
  } msize_t;

  typedef struct packed {
    logic              valid;
    logic [XLEN-1:0]   addr;
    msize_t            size;
    logic [STRB_W-1:0] strobe;
    logic [XLEN-1:0]   data;
  } dbus_req_t;

  typedef struct packed {
    logic            addr_ok;
    logic            data_ok;
    logic [XLEN-1:0] data;
  } dbus_resp_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    DONE = 2'b10
  } mem_state_t;

  // Low address bits that must be zero for a naturally aligned access
  function automatic logic [2:0] size_low_mask(input msize_t size);
    case (size)
      MSIZE1:  return 3'b000;
      MSIZE2:  return 3'b001;
      MSIZE4:  return 3'b011;
      default: return 3'b111;
    endcase
  endfunction

endpackage

// File: rtl/mem_fmt.sv
// Data-bus formatting for the memory-access stage (purely combinational).
// Ports:
//   addr_off   - byte offset of the access within the 64-bit word
//   size       - access size
//   funct3     - instruction funct3 (selects load extension)
//   store_data - raw store operand
//   rdata      - raw load data returned by the bus
//   strobe     - byte-enable for stores
//   wdata      - store data shifted into its byte lanes
//   ldata      - load data shifted down and sign/zero-extended
module mem_fmt
  import common::*;
(
  input  logic [2:0]        addr_off,
  input  msize_t            size,
  input  logic [2:0]        funct3,
  input  logic [XLEN-1:0]   store_data,
  input  logic [XLEN-1:0]   rdata,
  output logic [STRB_W-1:0] strobe,
  output logic [XLEN-1:0]   wdata,
  output logic [XLEN-1:0]   ldata
);

  logic [5:0]        bit_off;
  logic [STRB_W-1:0] size_mask;
  logic [XLEN-1:0]   shifted;

  always_comb begin
    bit_off = {addr_off, 3'b000};

    case (size)
      MSIZE1:  size_mask = 8'h01;
      MSIZE2:  size_mask = 8'h03;
      MSIZE4:  size_mask = 8'h0F;
      default: size_mask = 8'hFF;
    endcase

    strobe  = size_mask << addr_off;
    wdata   = store_data << bit_off;
    shifted = rdata >> bit_off;

    case (funct3)
      F3_LB:   ldata = {{56{shifted[7]}},  shifted[7:0]};
      F3_LH:   ldata = {{48{shifted[15]}}, shifted[15:0]};
      F3_LW:   ldata = {{32{shifted[31]}}, shifted[31:0]};
      F3_LBU:  ldata = {56'd0, shifted[7:0]};
      F3_LHU:  ldata = {48'd0, shifted[15:0]};
      F3_LWU:  ldata = {32'd0, shifted[31:0]};
      F3_LD:   ldata = shifted;
      default: ldata = shifted;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// Memory-access stage of the in-order pipeline: issues one data-bus
// transaction per load/store, stalls until the response, formats load data.
// Optional feature macro: MEM_MISALIGN_CHK_EN (flag misaligned accesses
// instead of silently aligning the address).
// Ports:
//   clk, reset                       - clock, async active-high reset
//   valid_in, advance_in             - EX/MEM holds an instruction / pipeline advances
//   ALU_result_in, reg_Q2_in         - address (or passthrough value) / store data
//   control_in, instr_in, PC_in      - control word, instruction, PC
//   dreq, dresp                      - data-bus request / response
//   stall_out                        - stage cannot complete this cycle
//   result_out                       - load data or ALU passthrough
//   control_out, instr_out, PC_out   - passthrough
//   misalign_out                     - misaligned-access flag
module mem_access_stage
  import common::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               valid_in,
  input  logic               advance_in,
  input  logic [XLEN-1:0]    ALU_result_in,
  input  logic [XLEN-1:0]    reg_Q2_in,
  input  logic [CTRL_W-1:0]  control_in,
  input  logic [INSTR_W-1:0] instr_in,
  input  logic [XLEN-1:0]    PC_in,
  output dbus_req_t          dreq,
  input  dbus_resp_t         dresp,
  output logic               stall_out,
  output logic [XLEN-1:0]    result_out,
  output logic [CTRL_W-1:0]  control_out,
  output logic [INSTR_W-1:0] instr_out,
  output logic [XLEN-1:0]    PC_out,
  output logic               misalign_out
);

  mem_state_t        state;
  logic [XLEN-1:0]   ldata_q;

  logic [2:0]        funct3;
  msize_t            size;
  logic              is_load;
  logic              is_store;
  logic              memop;
  logic              misalign;
  logic              can_issue;
  logic              req_valid;
  logic [2:0]        low_mask;
  logic [XLEN-1:0]   issue_addr;
  logic [STRB_W-1:0] fmt_strobe;
  logic [XLEN-1:0]   fmt_wdata;
  logic [XLEN-1:0]   fmt_ldata;
  logic              unused_addr_ok;

  // Decode; a word with both memory bits set is treated as a load
  assign funct3         = instr_in[14:12];
  assign size           = msize_t'(funct3[1:0]);
  assign is_load        = control_in[CTRL_MEMRD];
  assign is_store       = control_in[CTRL_MEMWR] & ~is_load;
  assign memop          = valid_in & (is_load | is_store);
  assign low_mask       = size_low_mask(size);
  assign unused_addr_ok = dresp.addr_ok;

`ifdef MEM_MISALIGN_CHK_EN
  assign issue_addr = ALU_result_in;
  assign misalign   = memop && ((ALU_result_in[2:0] & low_mask) != 3'b000);
`else
  // Force natural alignment of the issued address
  assign issue_addr = {ALU_result_in[XLEN-1:3], ALU_result_in[2:0] & ~low_mask};
  assign misalign   = 1'b0;
`endif

  assign can_issue = (state == IDLE) && memop && !misalign;

  mem_fmt u_fmt (
    .addr_off   (issue_addr[2:0]),
    .size       (size),
    .funct3     (funct3),
    .store_data (reg_Q2_in),
    .rdata      (dresp.data),
    .strobe     (fmt_strobe),
    .wdata      (fmt_wdata),
    .ldata      (fmt_ldata)
  );

  // Transaction FSM and captured load data
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      ldata_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (can_issue) begin
            if (dresp.data_ok) begin
              ldata_q <= fmt_ldata;
              state   <= DONE;
            end else begin
              state   <= WAIT;
            end
          end
        end
        WAIT: begin
          if (dresp.data_ok) begin
            ldata_q <= fmt_ldata;
            state   <= DONE;
          end
        end
        DONE: begin
          if (advance_in) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Request, stall and result; reset kills any visible request at once
  always_comb begin
    req_valid = !reset && (can_issue || (state == WAIT));

    dreq = '0;
    if (req_valid) begin
      dreq.valid = 1'b1;
      dreq.addr  = issue_addr;
      dreq.size  = size;
      if (is_store) begin
        dreq.strobe = fmt_strobe;
        dreq.data   = fmt_wdata;
      end
    end

    stall_out    = req_valid;
    misalign_out = !reset && (state == IDLE) && misalign;

    if ((state == DONE) && is_load) begin
      result_out = ldata_q;
    end else if (misalign_out && is_load) begin
      result_out = '0;
    end else begin
      result_out = ALU_result_in;
    end
  end

  assign control_out = control_in;
  assign instr_out   = instr_in;
  assign PC_out      = PC_in;

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: directed vector table, directed
// multi-cycle sequences and random loads/stores against a byte-level model.
module tb_mem_access_stage;
  import common::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_in;
  logic        advance_in;
  logic [63:0] ALU_result_in;
  logic [63:0] reg_Q2_in;
  logic [23:0] control_in;
  logic [31:0] instr_in;
  logic [63:0] PC_in;
  dbus_req_t   dreq;
  dbus_resp_t  dresp;
  logic        stall_out;
  logic [63:0] result_out;
  logic [23:0] control_out;
  logic [31:0] instr_out;
  logic [63:0] PC_out;
  logic        misalign_out;

  int n_checks = 0;
  int n_fails  = 0;

  msize_t sizes [4] = '{MSIZE1, MSIZE2, MSIZE4, MSIZE8};

  always #5 clk = ~clk;

  mem_access_stage dut (
    .clk           (clk),
    .reset         (reset),
    .valid_in      (valid_in),
    .advance_in    (advance_in),
    .ALU_result_in (ALU_result_in),
    .reg_Q2_in     (reg_Q2_in),
    .control_in    (control_in),
    .instr_in      (instr_in),
    .PC_in         (PC_in),
    .dreq          (dreq),
    .dresp         (dresp),
    .stall_out     (stall_out),
    .result_out    (result_out),
    .control_out   (control_out),
    .instr_out     (instr_out),
    .PC_out        (PC_out),
    .misalign_out  (misalign_out)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Load value built byte by byte from the returned word, then extended
  function automatic logic [63:0] model_load(input logic [63:0] rd, input int off,
                                             input logic [2:0] f3);
    int n;
    logic [63:0] v;
    n = 1 << f3[1:0];
    v = '0;
    for (int i = 0; i < n; i++)
      v = v | (((rd >> (8 * (off + i))) & 64'hFF) << (8 * i));
    if (!f3[2] && n < 8 && (((v >> (8 * n - 1)) & 64'd1) == 64'd1))
      v = v | ~((64'd1 << (8 * n)) - 64'd1);
    return v;
  endfunction

  function automatic logic [7:0] model_strobe(input int n, input int off);
    logic [7:0] s;
    s = '0;
    for (int i = 0; i < n; i++) s = s | 8'(1 << (off + i));
    return s;
  endfunction

  task automatic bubble();
    valid_in   = 1'b0;
    advance_in = 1'b0;
    control_in = '0;
  endtask

  // One load/store: lat = cycles from issue to data_ok, hold = extra DONE cycles
  task automatic do_mem(input string tag, input bit ld, input logic [63:0] a,
                        input logic [63:0] q2, input logic [2:0] f3, input int lat,
                        input int hold, input logic [63:0] rd);
    int n, off;
    bit mis;
    logic [63:0] ea, ed, er;
    logic [7:0] es;
    n   = 1 << f3[1:0];
    mis = (a % 64'(n)) != 64'd0;
`ifdef MEM_MISALIGN_CHK_EN
    ea = a;
`else
    ea  = a - (a % 64'(n));
    mis = 1'b0;
`endif
    off = int'(ea % 64'd8);
    es  = ld ? 8'h00 : model_strobe(n, off);
    ed  = q2 << (8 * off);
    er  = ld ? model_load(rd, off, f3) : a;

    valid_in      = 1'b1;
    advance_in    = 1'b0;
    control_in    = ld ? 24'h000010 : 24'h000020;
    instr_in      = {17'h0, f3, 12'h003};
    ALU_result_in = a;
    reg_Q2_in     = q2;
    PC_in         = {$urandom, $urandom};
    dresp         = '0;

    if (mis) begin
      @(negedge clk);
      chk({tag, "_mis_req"},   64'(dreq.valid),   64'd0);
      chk({tag, "_mis_stall"}, 64'(stall_out),    64'd0);
      chk({tag, "_mis_flag"},  64'(misalign_out), 64'd1);
      chk({tag, "_mis_res"},   result_out, ld ? 64'd0 : a);
      @(posedge clk); #1;
      bubble();
      return;
    end

    for (int c = 0; c <= lat; c++) begin
      dresp.data_ok = (c == lat);
      dresp.data    = (c == lat) ? rd : ~rd;
      @(negedge clk);
      chk({tag, "_req"},   64'(dreq.valid),   64'd1);
      chk({tag, "_stall"}, 64'(stall_out),    64'd1);
      chk({tag, "_addr"},  dreq.addr,         ea);
      chk({tag, "_size"},  64'(dreq.size),    64'(sizes[f3[1:0]]));
      chk({tag, "_strb"},  64'(dreq.strobe),  64'(es));
      chk({tag, "_mflag"}, 64'(misalign_out), 64'd0);
      chk({tag, "_wres"},  result_out,        a);
      if (!ld) chk({tag, "_wdata"}, dreq.data, ed);
      @(posedge clk); #1;
    end
    dresp = '0;

    for (int h = 0; h <= hold; h++) begin
      @(negedge clk);
      chk({tag, "_done_req"},   64'(dreq.valid), 64'd0);
      chk({tag, "_done_stall"}, 64'(stall_out),  64'd0);
      chk({tag, "_done_res"},   result_out,      er);
      if (h < hold) begin
        @(posedge clk); #1;
      end
    end
    advance_in = 1'b1;
    @(posedge clk); #1;
    bubble();
  endtask

  typedef struct {
    logic        v;
    logic [23:0] ctrl;
    logic [63:0] alu;
    logic        adv;
    logic        exp_stall;
    logic        exp_req;
    logic [63:0] exp_res;
  } vec_t;

  vec_t vecs [6];

  initial begin
    reset = 1'b1;
    bubble();
    ALU_result_in = 64'h77;
    reg_Q2_in     = '0;
    instr_in      = 32'h0000_0033;
    PC_in         = 64'h100;
    dresp         = '0;

    // Reset state
    @(negedge clk);
    chk("rst_req",    64'(dreq.valid),   64'd0);
    chk("rst_addr",   dreq.addr,         64'd0);
    chk("rst_strb",   64'(dreq.strobe),  64'd0);
    chk("rst_data",   dreq.data,         64'd0);
    chk("rst_stall",  64'(stall_out),    64'd0);
    chk("rst_mflag",  64'(misalign_out), 64'd0);
    chk("rst_ldata",  dut.ldata_q,       64'd0);
    chk("rst_res",    result_out,        64'h77);
    @(posedge clk); #1;
    reset = 1'b0;

    // Single-cycle vector table: non-memory and bubble cases
    vecs[0] = '{1'b1, 24'h000000, 64'h1234,                1'b1, 1'b0, 1'b0, 64'h1234};
    vecs[1] = '{1'b0, 24'h000010, 64'h1008,                1'b0, 1'b0, 1'b0, 64'h1008};
    vecs[2] = '{1'b0, 24'h000020, 64'h2001,                1'b1, 1'b0, 1'b0, 64'h2001};
    vecs[3] = '{1'b0, 24'h000030, 64'h3003,                1'b0, 1'b0, 1'b0, 64'h3003};
    vecs[4] = '{1'b1, 24'hFFFFCF, 64'hDEAD_BEEF_CAFE_F00D, 1'b0, 1'b0, 1'b0, 64'hDEAD_BEEF_CAFE_F00D};
    vecs[5] = '{1'b1, 24'h000001, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF};
    for (int i = 0; i < 6; i++) begin
      valid_in      = vecs[i].v;
      control_in    = vecs[i].ctrl;
      ALU_result_in = vecs[i].alu;
      advance_in    = vecs[i].adv;
      instr_in      = $urandom;
      PC_in         = {$urandom, $urandom};
      @(negedge clk);
      chk($sformatf("vec%0d_stall", i), 64'(stall_out),  64'(vecs[i].exp_stall));
      chk($sformatf("vec%0d_req", i),   64'(dreq.valid), 64'(vecs[i].exp_req));
      chk($sformatf("vec%0d_res", i),   result_out,      vecs[i].exp_res);
      chk($sformatf("vec%0d_ctrl", i),  64'(control_out), 64'(control_in));
      chk($sformatf("vec%0d_instr", i), 64'(instr_out),   64'(instr_in));
      chk($sformatf("vec%0d_pc", i),    PC_out,           PC_in);
      chk($sformatf("vec%0d_mflag", i), 64'(misalign_out), 64'd0);
      @(posedge clk); #1;
    end
    bubble();

    // Directed multi-cycle cases
    do_mem("lb",    1'b1, 64'h1003, 64'd0,    F3_LB, 2, 0, 64'h0000_0000_8000_0000);
    do_mem("sh",    1'b0, 64'h2006, 64'hABCD, 3'b001, 2, 0, 64'd0);
    do_mem("ld",    1'b1, 64'h3000, 64'd0,    F3_LD, 0, 3, 64'h0123_4567_89AB_CDEF);
    do_mem("lw_mis", 1'b1, 64'h4002, 64'd0,   F3_LW, 1, 0, 64'h1122_3344_5566_7788);

    // Reset asserted while a request is outstanding
    valid_in      = 1'b1;
    control_in    = 24'h000010;
    instr_in      = {17'h0, F3_LW, 12'h003};
    ALU_result_in = 64'h5000;
    dresp         = '0;
    @(negedge clk);
    chk("rw_issue_req", 64'(dreq.valid), 64'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rw_wait_req", 64'(dreq.valid), 64'd1);
    chk("rw_wait_stall", 64'(stall_out), 64'd1);
    #1 reset = 1'b1;
    #1;
    chk("rw_rst_req",   64'(dreq.valid), 64'd0);
    chk("rw_rst_stall", 64'(stall_out),  64'd0);
    chk("rw_rst_ldata", dut.ldata_q,     64'd0);
    @(posedge clk); #1;
    bubble();
    reset         = 1'b0;
    dresp.data_ok = 1'b1;
    dresp.data    = 64'hFFFF_0000_FFFF_0000;
    @(negedge clk);
    chk("rw_stray_req",   64'(dreq.valid), 64'd0);
    chk("rw_stray_stall", 64'(stall_out),  64'd0);
    @(posedge clk); #1;
    dresp = '0;
    @(negedge clk);
    chk("rw_after_ldata", dut.ldata_q,     64'd0);
    chk("rw_after_stall", 64'(stall_out),  64'd0);
    chk("rw_after_res",   result_out,      64'h5000);
    @(posedge clk); #1;

    // Random loads, stores and non-memory instructions
    for (int k = 0; k < 40; k++) begin
      int r;
      r = int'($urandom_range(0, 3));
      if (r == 0) begin
        valid_in      = 1'($urandom);
        control_in    = 24'($urandom);
        if (valid_in) control_in = control_in & 24'hFFFFCF;
        ALU_result_in = {$urandom, $urandom};
        advance_in    = 1'($urandom);
        @(negedge clk);
        chk("rnd_np_stall", 64'(stall_out),  64'd0);
        chk("rnd_np_req",   64'(dreq.valid), 64'd0);
        chk("rnd_np_res",   result_out,      ALU_result_in);
        @(posedge clk); #1;
        bubble();
      end else begin
        logic [63:0] a, q2, rd;
        logic [2:0]  f3;
        bit ld;
        ld = (r == 1);
        a  = {$urandom, $urandom};
        q2 = {$urandom, $urandom};
        rd = {$urandom, $urandom};
        f3 = ld ? 3'($urandom_range(0, 6)) : 3'($urandom_range(0, 3));
        do_mem(ld ? "rnd_ld" : "rnd_st", ld, a, q2, f3,
               int'($urandom_range(0, 3)), int'($urandom_range(0, 1)), rd);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
